// File: rtl/write_request_queue.sv
// CPU-to-RAM write-request queue: DEPTH-entry FIFO with ROM/IO-window filtering,
// sticky overflow and saturating filter statistics. Optional WRITE_COALESCE_EN macro.
module write_request_queue #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int RAM_LIMIT  = 'h3000,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  ram_clock,
  input  logic                  ram_reset_n,
  input  logic                  cpu_write_enable,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  input  logic                  ram_write_ready,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  queue_full,
  output logic                  overflow,
  input  logic                  overflow_clear,
  output logic [CNT_WIDTH-1:0]  filtered_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LIMIT_C = (ADDR_WIDTH+1)'(RAM_LIMIT);

  logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];

  logic [CNT_W-1:0] count, count_next;
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_ptr_next, newest_ptr, write_ptr;
  logic             in_range, push_valid, filtered, pop;
  logic             coalesce, accept, reject, write_en;
  logic [ADDR_WIDTH-1:0] head_addr_next;
  logic [DATA_WIDTH-1:0] head_data_next;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    in_range   = ({1'b0, cpu_addr} < LIMIT_C);
    push_valid = cpu_write_enable && in_range;
    filtered   = cpu_write_enable && !in_range;
    pop        = ram_write_enable && ram_write_ready;
    newest_ptr = wr_ptr - 1'b1;
`ifdef WRITE_COALESCE_EN
    // count >= 2 guarantees the newest entry is not the head being presented
    coalesce   = push_valid && (count >= CNT_W'(2)) && (mem_addr[newest_ptr] == cpu_addr);
`else
    coalesce   = 1'b0;
`endif
    accept      = push_valid && !coalesce && ((count != DEPTH_C) || pop);
    reject      = push_valid && !coalesce && !accept;
    write_en    = accept || coalesce;
    write_ptr   = coalesce ? newest_ptr : wr_ptr;
    count_next  = count + CNT_W'(accept) - CNT_W'(pop);
    rd_ptr_next = rd_ptr + PTR_W'(pop);
  end

  // Next head: bypass the incoming request when it lands in the slot about to be presented
  always_comb begin
    head_addr_next = ram_addr;
    head_data_next = ram_data;
    if (count_next != '0) begin
      if (write_en && (write_ptr == rd_ptr_next)) begin
        head_addr_next = cpu_addr;
        head_data_next = cpu_data;
      end else begin
        head_addr_next = mem_addr[rd_ptr_next];
        head_data_next = mem_data[rd_ptr_next];
      end
    end
  end

  always_ff @(posedge ram_clock) begin
    if (write_en) begin
      mem_addr[write_ptr] <= cpu_addr;
      mem_data[write_ptr] <= cpu_data;
    end
  end

  always_ff @(posedge ram_clock or negedge ram_reset_n) begin
    if (!ram_reset_n) begin
      count            <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      ram_write_enable <= 1'b0;
      ram_addr         <= '0;
      ram_data         <= '0;
      overflow         <= 1'b0;
      filtered_count   <= '0;
    end else begin
      count            <= count_next;
      rd_ptr           <= rd_ptr_next;
      wr_ptr           <= accept ? wr_ptr + 1'b1 : wr_ptr;
      ram_write_enable <= (count_next != '0);
      ram_addr         <= head_addr_next;
      ram_data         <= head_data_next;
      overflow         <= reject || (overflow && !overflow_clear);
      filtered_count   <= filtered ? sat_inc(filtered_count) : filtered_count;
    end
  end

  assign queue_full = (count == DEPTH_C);

endmodule
